// File: rtl/sram_port_arbiter.sv
// Arbitrates one single-port, 1-cycle-latency SRAM between instruction fetch
// and MEM-stage data requesters, holding responses the owner is not ready for.
module sram_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic                clk,
    input  logic                resetn,

    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [DATA_W-1:0]   inst_rdata,
    input  logic                inst_resp_rdy,

    input  logic                data_req,
    input  logic                data_wr,
    input  logic [DATA_W/8-1:0] data_wstrb,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,
    input  logic                data_resp_rdy,

    output logic                sram_en,
    output logic [DATA_W/8-1:0] sram_we,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [DATA_W-1:0]   sram_wdata,
    input  logic [DATA_W-1:0]   sram_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HOLD
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t              state, state_nxt;
    logic                owner, owner_nxt;
    logic                owner_wr, owner_wr_nxt;
    logic [DATA_W-1:0]   hold_buf, hold_buf_nxt;
    logic [3:0]          starve_cnt, starve_cnt_nxt;

    logic                owner_rdy;
    logic                issue_ok;
    logic                starve_win;
    logic                grant_inst;
    logic                grant_data;
    logic                resp_valid;
    logic [DATA_W-1:0]   resp_data;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            owner      <= 1'b0;
            owner_wr   <= 1'b0;
            hold_buf   <= '0;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            owner_wr   <= owner_wr_nxt;
            hold_buf   <= hold_buf_nxt;
            starve_cnt <= starve_cnt_nxt;
        end
    end

    // resetn gates issue so nothing is granted while reset is asserted
    always_comb begin
        owner_rdy  = owner ? data_resp_rdy : inst_resp_rdy;
        issue_ok   = resetn && ((state == IDLE) || owner_rdy);
        starve_win = inst_req && data_req && (starve_cnt == STARVE_LIM);
        grant_inst = issue_ok && inst_req && (starve_win || !data_req);
        grant_data = issue_ok && data_req && !starve_win;
        resp_data  = (state == HOLD) ? hold_buf
                                     : (owner_wr ? '0 : sram_rdata);

        state_nxt      = state;
        owner_nxt      = owner;
        owner_wr_nxt   = owner_wr;
        hold_buf_nxt   = hold_buf;
        starve_cnt_nxt = starve_cnt;

        if (issue_ok) begin
            if (grant_inst || grant_data) begin
                state_nxt    = WAIT;
                owner_nxt    = grant_data;
                owner_wr_nxt = grant_data && data_wr;
            end else begin
                state_nxt = IDLE;
            end
            if (grant_inst || !inst_req) begin
                starve_cnt_nxt = '0;
            end else if (grant_data && (starve_cnt != STARVE_LIM)) begin
                starve_cnt_nxt = starve_cnt + 4'd1;
            end
        end else if (state == WAIT) begin
            state_nxt    = HOLD;
            hold_buf_nxt = resp_data;
        end
    end

    always_comb begin
        resp_valid   = (state != IDLE);
        inst_addr_ok = grant_inst;
        data_addr_ok = grant_data;
        inst_data_ok = resp_valid && !owner;
        data_data_ok = resp_valid && owner;
        inst_rdata   = inst_data_ok ? resp_data : '0;
        data_rdata   = data_data_ok ? resp_data : '0;
        sram_en      = grant_inst || grant_data;
        sram_we      = (grant_data && data_wr) ? data_wstrb : '0;
        sram_addr    = grant_data ? data_addr : (grant_inst ? inst_addr : '0);
        sram_wdata   = grant_data ? data_wdata : '0;
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: behavioural SRAM, directed scenarios
// and a constrained-random traffic phase with response ordering checks.
module tb_sram_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;

    logic          clk;
    logic          resetn;
    logic          inst_req;
    logic [AW-1:0] inst_addr;
    logic          inst_addr_ok;
    logic          inst_data_ok;
    logic [DW-1:0] inst_rdata;
    logic          inst_resp_rdy;
    logic          data_req;
    logic          data_wr;
    logic [SW-1:0] data_wstrb;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_wdata;
    logic          data_addr_ok;
    logic          data_data_ok;
    logic [DW-1:0] data_rdata;
    logic          data_resp_rdy;
    logic          sram_en;
    logic [SW-1:0] sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;

    sram_port_arbiter #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .STARVE_MAX(3)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .inst_resp_rdy(inst_resp_rdy),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .data_resp_rdy(data_resp_rdy),
        .sram_en      (sram_en),
        .sram_we      (sram_we),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int unsigned i);
        case (i)
            4:       return 32'hdeadbeef;
            8:       return 32'hffffffff;
            12:      return 32'haabbccdd;
            default: return 32'h10000000 + 32'(i) * 32'h00010101;
        endcase
    endfunction

    // Behavioural SRAM; returns junk when no read was issued the previous cycle
    logic [31:0] mem [64];
    always @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(32'(i));
        end else if (sram_en) begin
            sram_rdata <= mem[sram_addr[7:2]];
            for (int b = 0; b < 4; b++)
                if (sram_we[b]) mem[sram_addr[7:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
        end else begin
            sram_rdata <= $urandom;
        end
    end

    typedef struct packed {
        logic        who;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t head;
    exp_t push_e;
    logic inst_acc;
    logic data_acc;

    always @(negedge clk) begin
        if (!resetn) begin
            sb.delete();
            inst_acc = 1'b0;
            data_acc = 1'b0;
        end else begin
            if (sb.size() > 0) begin
                head = sb[0];
                chk("resp_ok", 64'({inst_data_ok, data_data_ok}), 64'(head.who ? 2'b01 : 2'b10));
                chk("resp_data", 64'(head.who ? data_rdata : inst_rdata), 64'(head.data));
                if (head.who ? data_resp_rdy : inst_resp_rdy) void'(sb.pop_front());
            end else begin
                chk("no_resp", 64'({inst_data_ok, data_data_ok}), 64'(0));
            end
            chk("en_vs_grant", 64'(sram_en), 64'(inst_addr_ok | data_addr_ok));
            chk("one_grant", 64'(inst_addr_ok & data_addr_ok), 64'(0));
            if (data_addr_ok) begin
                chk("d_addr", 64'(sram_addr), 64'(data_addr));
                chk("d_we", 64'(sram_we), 64'(data_wr ? data_wstrb : 4'b0000));
                if (data_wr) chk("d_wdata", 64'(sram_wdata), 64'(data_wdata));
                push_e.who  = 1'b1;
                push_e.data = data_wr ? 32'h0 : mem[data_addr[7:2]];
                sb.push_back(push_e);
            end else if (inst_addr_ok) begin
                chk("i_addr", 64'(sram_addr), 64'(inst_addr));
                chk("i_we", 64'(sram_we), 64'(0));
                push_e.who  = 1'b0;
                push_e.data = mem[inst_addr[7:2]];
                sb.push_back(push_e);
            end else begin
                chk("idle_we", 64'(sram_we), 64'(0));
            end
            inst_acc = inst_addr_ok;
            data_acc = data_addr_ok;
        end
    end

    task automatic idle(input int unsigned n);
        inst_req = 1'b0;
        data_req = 1'b0;
        data_wr  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input logic is_data);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            hit = is_data ? data_addr_ok : inst_addr_ok;
        end
        chk("grant_wait", 64'(hit), 64'(1));
        @(posedge clk);
        #1;
        if (is_data) data_req = 1'b0;
        else inst_req = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [5:0] idx;
        idx = 6'($urandom_range(0, 63));
        return {24'h1c0000, idx, 2'b00};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn        = 1'b0;
        inst_req      = 1'b1;
        data_req      = 1'b1;
        data_wr       = 1'b0;
        data_wstrb    = 4'hf;
        inst_addr     = 32'h1c000040;
        data_addr     = 32'h1c000044;
        data_wdata    = 32'h0;
        inst_resp_rdy = 1'b1;
        data_resp_rdy = 1'b1;

        // reset with both requests pending
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outs", 64'({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, sram_en,
                             |sram_we, |sram_addr, |sram_wdata, |inst_rdata, |data_rdata}), 64'(0));
        @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk("rst_first_daok", 64'(data_addr_ok), 64'(1));
        chk("rst_first_en", 64'(sram_en), 64'(1));
        chk("rst_first_iaok", 64'(inst_addr_ok), 64'(0));
        @(posedge clk);
        #1 data_req = 1'b0;
        wait_grant(1'b0);

        // data read
        idle(3);
        data_addr = 32'h1c000010;
        data_req  = 1'b1;
        @(negedge clk);
        chk("rd_aok", 64'(data_addr_ok), 64'(1));
        @(posedge clk);
        #1 data_req = 1'b0;
        @(negedge clk);
        chk("rd_dok", 64'(data_data_ok), 64'(1));
        chk("rd_data", 64'(data_rdata), 64'(32'hdeadbeef));

        // partial write, then read back
        idle(3);
        data_addr  = 32'h1c000020;
        data_wr    = 1'b1;
        data_wstrb = 4'b0011;
        data_wdata = 32'h12345678;
        data_req   = 1'b1;
        @(negedge clk);
        chk("wr_aok", 64'(data_addr_ok), 64'(1));
        chk("wr_we", 64'(sram_we), 64'(4'b0011));
        chk("wr_wdata", 64'(sram_wdata), 64'(32'h12345678));
        @(posedge clk);
        #1;
        data_req = 1'b0;
        data_wr  = 1'b0;
        @(negedge clk);
        chk("wr_dok", 64'(data_data_ok), 64'(1));
        chk("wr_rdata", 64'(data_rdata), 64'(0));
        idle(2);
        data_req = 1'b1;
        wait_grant(1'b1);
        @(negedge clk);
        chk("wr_readback", 64'(data_rdata), 64'(32'hffff5678));
        @(posedge clk);
        #1;

        // starvation guard: D,D,D,I repeating
        idle(3);
        inst_addr = 32'h1c000030;
        data_addr = 32'h1c000010;
        inst_req  = 1'b1;
        data_req  = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("starve_seq", 64'({inst_addr_ok, data_addr_ok}), 64'((i % 4 == 3) ? 2'b10 : 2'b01));
            @(posedge clk);
            #1;
        end

        // backpressure on fetch response with data pending
        idle(3);
        inst_addr     = 32'h1c000030;
        inst_resp_rdy = 1'b0;
        inst_req      = 1'b1;
        @(negedge clk);
        chk("bp_iaok", 64'(inst_addr_ok), 64'(1));
        @(posedge clk);
        #1;
        inst_req  = 1'b0;
        data_addr = 32'h1c000010;
        data_req  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_dok", 64'(inst_data_ok), 64'(1));
            chk("bp_data", 64'(inst_rdata), 64'(32'haabbccdd));
            chk("bp_en", 64'(sram_en), 64'(0));
            chk("bp_daok", 64'(data_addr_ok), 64'(0));
            @(posedge clk);
            #1;
        end
        inst_resp_rdy = 1'b1;
        @(negedge clk);
        chk("bp_rel_dok", 64'(inst_data_ok), 64'(1));
        chk("bp_rel_data", 64'(inst_rdata), 64'(32'haabbccdd));
        chk("bp_rel_daok", 64'(data_addr_ok), 64'(1));
        chk("bp_rel_en", 64'(sram_en), 64'(1));
        @(posedge clk);
        #1 data_req = 1'b0;
        @(negedge clk);
        chk("bp_next_dok", 64'(data_data_ok), 64'(1));
        chk("bp_next_data", 64'(data_rdata), 64'(32'hdeadbeef));

        // reset while a response is due
        idle(3);
        data_addr = 32'h1c000010;
        data_req  = 1'b1;
        @(negedge clk);
        chk("mid_aok", 64'(data_addr_ok), 64'(1));
        @(posedge clk);
        #1;
        data_req = 1'b0;
        chk("mid_dok_pre", 64'(data_data_ok), 64'(1));
        resetn = 1'b0;
        #1;
        chk("mid_dok_rst", 64'({inst_data_ok, data_data_ok}), 64'(0));
        chk("mid_rdata_rst", 64'(data_rdata), 64'(0));
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mid_no_stale", 64'({inst_data_ok, data_data_ok}), 64'(0));
        end
        @(posedge clk);
        #1;

        // random traffic
        idle(2);
        for (int c = 0; c < 400; c++) begin
            if (!inst_req || inst_acc) begin
                inst_req  = 1'($urandom_range(0, 1));
                inst_addr = rand_addr();
            end
            if (!data_req || data_acc) begin
                data_req   = 1'($urandom_range(0, 1));
                data_addr  = rand_addr();
                data_wr    = 1'($urandom_range(0, 1));
                data_wstrb = 4'($urandom_range(0, 15));
                data_wdata = $urandom;
            end
            inst_resp_rdy = ($urandom_range(0, 3) != 0);
            data_resp_rdy = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        inst_resp_rdy = 1'b1;
        data_resp_rdy = 1'b1;
        if (inst_req) wait_grant(1'b0);
        if (data_req) wait_grant(1'b1);
        idle(5);
        chk("drain", 64'(sb.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
